// File: rtl/cavlc_bit_packer_if.sv
// Handshake bundle between the CAVLC code producer, the bit packer and the
// word write-back path.
interface cavlc_bit_packer_if;
    logic         cavlc_enc_valid;
    logic [127:0] cavlc_bitstream_code;
    logic [6:0]   cavlc_bitstream_bit;
    logic         packer_ready;
    logic         flush;
    logic         flush_done;
    logic         word_valid;
    logic         word_ready;
    logic [31:0]  out_word;
    logic [31:0]  out_addr;
    logic [15:0]  word_count;

    // Producer of codes and consumer of words
    modport master (
        output cavlc_enc_valid, cavlc_bitstream_code, cavlc_bitstream_bit, flush, word_ready,
        input  packer_ready, flush_done, word_valid, out_word, out_addr, word_count
    );

    // The packer itself
    modport slave (
        input  cavlc_enc_valid, cavlc_bitstream_code, cavlc_bitstream_bit, flush, word_ready,
        output packer_ready, flush_done, word_valid, out_word, out_addr, word_count
    );
endinterface

// File: rtl/cavlc_bit_packer.sv
// Packs variable-length CAVLC codes MSB-first into 32-bit addressed words,
// with an on-demand zero-padded flush of the residual bits.
module cavlc_bit_packer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ADDR_STEP = 32'd4
) (
    input  logic                clk,
    input  logic                rst,
    cavlc_bit_packer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_r, state_s;
    logic [159:0]   buf_r, buf_s;
    logic [7:0]     fill_r, fill_s;
    logic           flush_pending_r, flush_pending_s;
    logic [31:0]    out_addr_r, out_addr_s;
    logic [15:0]    word_count_r, word_count_s;
    logic           word_valid_r, word_valid_s;
    logic [31:0]    out_word_r, out_word_s;
    logic           flush_done_r, flush_done_s;

    logic           ready_s;
    logic           accept_s;
    logic [127:0]   code_masked_s;
    logic [7:0]     ins_shift_s;
    logic [159:0]   ins_s;

    // Ready depends only on registered state; held low while in reset
    assign ready_s  = !rst && (state_r == IDLE) && (fill_r < 8'd32) && !flush_pending_r;
    assign accept_s = bus.cavlc_enc_valid && ready_s;

    // Bits above the code length are ignored; the code lands just below the current fill
    assign code_masked_s = bus.cavlc_bitstream_code & ((128'd1 << bus.cavlc_bitstream_bit) - 128'd1);
    assign ins_shift_s   = 8'd160 - {1'b0, bus.cavlc_bitstream_bit} - fill_r;
    assign ins_s         = {32'd0, code_masked_s} << ins_shift_s;

    // Next-state, buffer and counter logic
    always_comb begin
        state_s         = state_r;
        buf_s           = buf_r;
        fill_s          = fill_r;
        flush_pending_s = flush_pending_r;
        out_addr_s      = out_addr_r;
        word_count_s    = word_count_r;
        case (state_r)
            IDLE: begin
                flush_pending_s = flush_pending_r | bus.flush;
                if (accept_s) begin
                    buf_s  = buf_r | ins_s;
                    fill_s = fill_r + {1'b0, bus.cavlc_bitstream_bit};
                end else begin
                    buf_s  = buf_r;
                    fill_s = fill_r;
                end
                if (fill_s >= 8'd32) begin
                    state_s = DRAIN;
                end else if (flush_pending_s) begin
                    state_s = FLUSH;
                end else begin
                    state_s = IDLE;
                end
            end
            DRAIN: begin
                flush_pending_s = flush_pending_r | bus.flush;
                if (bus.word_ready) begin
                    buf_s        = buf_r << 32;
                    fill_s       = fill_r - 8'd32;
                    out_addr_s   = out_addr_r + ADDR_STEP;
                    word_count_s = word_count_r + 16'd1;
                    if (fill_s >= 8'd32) begin
                        state_s = DRAIN;
                    end else if (flush_pending_s) begin
                        state_s = FLUSH;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = DRAIN;
                end
            end
            FLUSH: begin
                if (fill_r == 8'd0) begin
                    state_s = DONE;
                end else if (bus.word_ready) begin
                    buf_s        = 160'd0;
                    fill_s       = 8'd0;
                    out_addr_s   = out_addr_r + ADDR_STEP;
                    word_count_s = word_count_r + 16'd1;
                    state_s      = DONE;
                end else begin
                    state_s = FLUSH;
                end
            end
            DONE: begin
                flush_pending_s = 1'b0;
                state_s         = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output values computed one cycle ahead so the ports come straight from flops
    always_comb begin
        word_valid_s = (state_s == DRAIN) || ((state_s == FLUSH) && (fill_s != 8'd0));
        flush_done_s = (state_s == DONE);
        if (word_valid_s) begin
            out_word_s = buf_s[159:128] & ~(32'hFFFF_FFFF >> fill_s);
        end else begin
            out_word_s = 32'd0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= IDLE;
            buf_r           <= 160'd0;
            fill_r          <= 8'd0;
            flush_pending_r <= 1'b0;
            out_addr_r      <= BASE_ADDR;
            word_count_r    <= 16'd0;
            word_valid_r    <= 1'b0;
            out_word_r      <= 32'd0;
            flush_done_r    <= 1'b0;
        end else begin
            state_r         <= state_s;
            buf_r           <= buf_s;
            fill_r          <= fill_s;
            flush_pending_r <= flush_pending_s;
            out_addr_r      <= out_addr_s;
            word_count_r    <= word_count_s;
            word_valid_r    <= word_valid_s;
            out_word_r      <= out_word_s;
            flush_done_r    <= flush_done_s;
        end
    end

    assign bus.packer_ready = ready_s;
    assign bus.word_valid   = word_valid_r;
    assign bus.out_word     = out_word_r;
    assign bus.out_addr     = out_addr_r;
    assign bus.word_count   = word_count_r;
    assign bus.flush_done   = flush_done_r;

endmodule

// File: tb/tb_cavlc_bit_packer.sv
// Directed, table-driven bench for cavlc_bit_packer: single-code-plus-flush
// vectors from a table, then hand-written multi-cycle sequences.
module tb_cavlc_bit_packer;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [31:0] exp_addr;
    logic [15:0] exp_cnt;
    logic [31:0] wq[$];
    logic [31:0] aq[$];

    cavlc_bit_packer_if bus();

    cavlc_bit_packer #(.BASE_ADDR(32'h0000_0000), .ADDR_STEP(32'd4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [127:0]     code;
        logic [6:0]       len;
        int               nw;
        logic [3:0][31:0] w;
    } vec_t;

    vec_t tbl[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every word handed over to the write-back side
    always @(posedge clk) begin
        if (!rst && bus.word_valid && bus.word_ready) begin
            wq.push_back(bus.out_word);
            aq.push_back(bus.out_addr);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [127:0] c, input logic [6:0] l, input int nw,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
        tbl[i].code = c;
        tbl[i].len  = l;
        tbl[i].nw   = nw;
        tbl[i].w[0] = w0;
        tbl[i].w[1] = w1;
        tbl[i].w[2] = w2;
        tbl[i].w[3] = w3;
    endtask

    // Called at a negedge; returns at the negedge after the code was accepted
    task automatic send(input logic [127:0] c, input logic [6:0] l, input logic f);
        int n;
        n = 0;
        bus.cavlc_bitstream_code = c;
        bus.cavlc_bitstream_bit  = l;
        bus.cavlc_enc_valid      = 1'b1;
        bus.flush                = f;
        while (!bus.packer_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=not_ready required=ready");
        end
        @(negedge clk);
        bus.cavlc_enc_valid = 1'b0;
        bus.flush           = 1'b0;
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!bus.flush_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_flush_done"}, {31'd0, bus.flush_done}, 32'd1);
        @(negedge clk);
        chk({name, "_flush_done_pulse"}, {31'd0, bus.flush_done}, 32'd0);
    endtask

    task automatic check_words(input string name, input int nw, input logic [3:0][31:0] w);
        chk({name, "_nwords"}, wq.size(), nw);
        for (int k = 0; k < nw; k++) begin
            if (wq.size() > 0) begin
                chk({name, "_word"}, wq.pop_front(), w[k]);
                chk({name, "_addr"}, aq.pop_front(), exp_addr);
            end else begin
                checks++;
                failures++;
                $display("FAIL %s_missing_word actual=none required=%h", name, w[k]);
            end
            exp_addr = exp_addr + 32'd4;
            exp_cnt  = exp_cnt + 16'd1;
        end
        wq.delete();
        aq.delete();
        chk({name, "_word_count"}, {16'd0, bus.word_count}, {16'd0, exp_cnt});
    endtask

    initial begin
        logic [3:0][31:0] w;
        checks   = 0;
        failures = 0;
        exp_addr = 32'h0;
        exp_cnt  = 16'd0;

        set_vec(0, 128'h5,            7'd3,   1, 32'hA000_0000, 32'h0, 32'h0, 32'h0);
        set_vec(1, 128'h0,            7'd0,   0, 32'h0, 32'h0, 32'h0, 32'h0);
        set_vec(2, {128{1'b1}},       7'd100, 4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF000_0000);
        set_vec(3, 128'h1,            7'd1,   1, 32'h8000_0000, 32'h0, 32'h0, 32'h0);
        set_vec(4, 128'hABCD,         7'd16,  1, 32'hABCD_0000, 32'h0, 32'h0, 32'h0);
        set_vec(5, 128'hDEAD_BEEF,    7'd32,  1, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0);
        set_vec(6, 128'h1_2345_6789,  7'd33,  2, 32'h91A2_B3C4, 32'h8000_0000, 32'h0, 32'h0);
        set_vec(7, 128'hF0,           7'd4,   1, 32'h0000_0000, 32'h0, 32'h0, 32'h0);

        bus.cavlc_enc_valid      = 1'b0;
        bus.cavlc_bitstream_code = 128'd0;
        bus.cavlc_bitstream_bit  = 7'd0;
        bus.flush                = 1'b0;
        bus.word_ready           = 1'b1;
        rst = 1'b0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst_packer_ready", {31'd0, bus.packer_ready}, 32'd0);
        chk("rst_word_valid",   {31'd0, bus.word_valid},   32'd0);
        chk("rst_flush_done",   {31'd0, bus.flush_done},   32'd0);
        chk("rst_out_word",     bus.out_word, 32'd0);
        chk("rst_out_addr",     bus.out_addr, 32'h0);
        chk("rst_word_count",   {16'd0, bus.word_count}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready",   {31'd0, bus.packer_ready}, 32'd1);

        // Table: one code, then a flush
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].code, tbl[i].len, 1'b0);
            do_flush();
            wait_done($sformatf("vec%0d", i));
            check_words($sformatf("vec%0d", i), tbl[i].nw, tbl[i].w);
        end

        // Eight nibbles back-to-back fill exactly one word
        for (int i = 0; i < 8; i++) begin
            send(128'hF, 7'd4, 1'b0);
        end
        chk("b2b_word_valid",   {31'd0, bus.word_valid},   32'd1);
        chk("b2b_ready_drain",  {31'd0, bus.packer_ready}, 32'd0);
        chk("b2b_out_word",     bus.out_word, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("b2b_valid_after",  {31'd0, bus.word_valid},   32'd0);
        chk("b2b_ready_after",  {31'd0, bus.packer_ready}, 32'd1);
        do_flush();
        wait_done("b2b");
        w = {32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF};
        check_words("b2b", 1, w);

        // Back-pressure: word and address held, no code accepted during the stall
        bus.word_ready = 1'b0;
        send(128'h1234_5678, 7'd32, 1'b0);
        bus.cavlc_bitstream_code = 128'h7;
        bus.cavlc_bitstream_bit  = 7'd3;
        bus.cavlc_enc_valid      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'd0, bus.word_valid},   32'd1);
            chk("stall_word",  bus.out_word, 32'h1234_5678);
            chk("stall_addr",  bus.out_addr, exp_addr);
            chk("stall_ready", {31'd0, bus.packer_ready}, 32'd0);
            @(negedge clk);
        end
        bus.cavlc_enc_valid = 1'b0;
        bus.word_ready      = 1'b1;
        @(negedge clk);
        do_flush();
        wait_done("stall");
        w = {32'h0, 32'h0, 32'h0, 32'h1234_5678};
        check_words("stall", 1, w);

        // Flush together with a 40-bit code: full word, then 8-bit residual
        send(128'hAB_CDEF_0123, 7'd40, 1'b1);
        wait_done("flush_with_code");
        w = {32'h0, 32'h0, 32'h2300_0000, 32'hABCD_EF01};
        check_words("flush_with_code", 2, w);

        // Reset in the middle of a stalled word
        bus.word_ready = 1'b0;
        send(128'hCAFE_F00D, 7'd32, 1'b0);
        chk("mid_rst_valid_before", {31'd0, bus.word_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, bus.word_valid},   32'd0);
        chk("mid_rst_addr",  bus.out_addr, 32'h0);
        chk("mid_rst_count", {16'd0, bus.word_count},   32'd0);
        chk("mid_rst_ready", {31'd0, bus.packer_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.word_ready = 1'b1;
        #1;
        chk("mid_rst_ready_release", {31'd0, bus.packer_ready}, 32'd1);
        @(negedge clk);
        wq.delete();
        aq.delete();
        exp_addr = 32'h0;
        exp_cnt  = 16'd0;
        do_flush();
        wait_done("after_rst");
        w = {32'h0, 32'h0, 32'h0, 32'h0};
        check_words("after_rst", 0, w);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cavlc_bit_packer.md
Name: cavlc_bit_packer

Overview:
Consumer end of the CAVLC encoder output interface. It accepts variable-length codes (up to 127 bits each) from CAVLCTop through a valid/ready handshake and packs them MSB-first into a continuous bitstream. It emits 32-bit words with incrementing byte addresses toward the bitstream write-back path. On request it flushes any residual bits, zero-padded to a word boundary.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first output word
ADDR_STEP, 4, byte increment between consecutive output words

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cavlc_enc_valid  in  1  code present on cavlc_bitstream_code/bit
cavlc_bitstream_code  in  128  code, right-aligned in bits [len-1:0], MSB emitted first
cavlc_bitstream_bit  in  7  code length in bits, 0..127
packer_ready  out  1  packer can accept a code this cycle
flush  in  1  single-cycle pulse: pad and emit residual bits
flush_done  out  1  one-cycle pulse when the flush has completed
word_valid  out  1  out_word/out_addr valid
word_ready  in  1  downstream accepts the word
out_word  out  32  packed bits; oldest bit at [31]
out_addr  out  32  byte address of out_word
word_count  out  16  total words emitted since reset

Behaviour:
- Reset (async, rst=1): state IDLE, fill=0, bit buffer=0, flush_pending=0, word_valid=0, out_word=0, out_addr=BASE_ADDR, word_count=0, flush_done=0, packer_ready=0 while rst is high.
- Internal buffer: 160 bits, left-aligned; fill 0..158. New code goes at positions fill..fill+len-1 from the MSB.
- States: IDLE, DRAIN, FLUSH, DONE.
- IDLE: packer_ready = 1 iff fill<32 and !flush_pending (combinational from registered state).
  - Accept on cavlc_enc_valid && packer_ready: fill += len.
  - If the new fill ≥ 32: go to DRAIN next cycle.
  - len=0 is accepted with no effect.
- DRAIN:
  - word_valid=1; out_word = buffer[159:128].
  - On word_ready: shift buffer left 32, fill -= 32, out_addr += ADDR_STEP, word_count += 1.
  - Remain in DRAIN while fill ≥ 32 after the shift. Otherwise go to FLUSH if flush_pending, else IDLE.
  - Latency: code accepted in cycle N, first word valid in cycle N+1.
  - out_word and out_addr are held stable while word_valid && !word_ready.
- flush pulse: sets flush_pending (registered). If it arrives in the same cycle as a code acceptance, the code is accepted first and the flush follows. From IDLE with fill<32: go to FLUSH next cycle.
- FLUSH:
  - If fill>0: word_valid=1, out_word = buffer[159:128] with bits below fill forced to 0. On word_ready: fill=0, address and count advance, go to DONE.
  - If fill=0: go to DONE with no word emitted.
- DONE: flush_done=1 for one cycle, flush_pending cleared, return to IDLE.
- flush pulses received while flush_pending is already set are ignored.
- word_count wraps at 2^16. out_addr wraps modulo 2^32.
- Reset asserted mid-operation aborts immediately to reset values. A partially presented word is discarded.

Test Plan:
1. Code 0x5, len 3, then flush → exactly one word: 0xA000_0000 at addr 0x0; flush_done pulses one cycle later; word_count=1.
2. Eight codes 0xF, len 4, back-to-back → word 0xFFFF_FFFF valid the cycle after the 8th accept; packer_ready=0 during DRAIN; fill returns to 0.
3. One code of all ones, len 100 → three words 0xFFFF_FFFF at addrs 0x0, 0x4, 0x8; then flush → 0xF000_0000 at 0xC; word_count=4.
4. Hold word_ready=0 for 5 cycles during DRAIN → word_valid stays 1, out_word and out_addr unchanged, packer_ready=0, no code accepted.
5. Code len 0, then flush with fill=0 → no word emitted; flush_done pulses; word_count unchanged. Flush in the same cycle as a len-40 code accept → one full word, then a residual word with 8 valid bits, then flush_done.
6. Assert rst mid-DRAIN with word_valid=1 → word_valid=0, out_addr=BASE_ADDR, word_count=0 immediately; packer_ready=1 in the first cycle after release.
